multicycle_control: RTL and testbench

Multicycle sequencer for the Lab3 MIPS datapath. Decodes opcode/funct and steps the shared datapath (PC, IR, register file, single ALU, unified memory) through fetch/decode/execute/memory/writeback states, one instruction at a time. Memory accesses use a req/ready handshake. Supports LW, SW, J, JR, JAL, BNE, XORI, ADDI, ADD, SUB, SLT; anything else traps.

---
 rtl/mips_ctrl_pkg.sv | 96 +++++++++
 rtl/mips_ctrl_decode.sv | 67 ++++++
 rtl/multicycle_control.sv | 233 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the Lab3 multicycle MIPS controller:
//   - opcode / funct encodings of the supported instructions
//   - ALU operation encoding driven on alu_op
//   - controller state enum and instruction dispatch classes
//   - datapath mux-select encodings (pc_src, alu_src_a/b, reg_dst, mem_to_reg)
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation encoding seen by the datapath ALU
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_XOR = 3'd2,
    ALU_SLT = 3'd3
  } alu_op_t;

  // Controller states
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL       = 4'd12,
    S_JR        = 4'd13,
    S_ILLEGAL   = 4'd14
  } state_t;

  // Where DECODE sends each instruction
  typedef enum logic [2:0] {
    CLS_MEM     = 3'd0,
    CLS_R       = 3'd1,
    CLS_JR      = 3'd2,
    CLS_I       = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_JUMP    = 3'd5,
    CLS_JAL     = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instr_class_t;

  // pc_src: source of the next PC value
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  // alu_src_a
  localparam logic ALU_A_PC = 1'b0;
  localparam logic ALU_A_RS = 1'b1;

  // alu_src_b
  localparam logic [1:0] ALU_B_RT      = 2'd0;
  localparam logic [1:0] ALU_B_FOUR    = 2'd1;
  localparam logic [1:0] ALU_B_IMM     = 2'd2;
  localparam logic [1:0] ALU_B_IMM_SH2 = 2'd3;

  // reg_dst
  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  // mem_to_reg (register file write-data source)
  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  function automatic logic is_store_op(input logic [5:0] op);
    return op == OP_SW;
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// ---------------------------------------------------------------------------
// mips_ctrl_decode
// Purely combinational instruction decode for the multicycle controller.
// Classifies opcode/funct into the dispatch class used by the DECODE state
// and selects the ALU operation used in the execute states.
// Ports:
//   opcode      in  6  IR[31:26]
//   funct       in  6  IR[5:0]
//   instr_class out 3  instr_class_t dispatch class
//   is_store    out 1  memory class is SW (otherwise LW)
//   exec_alu_op out 3  ALU op for EXEC_R / EXEC_I
//   imm_zext    out 1  immediate is zero-extended (XORI)
// ---------------------------------------------------------------------------
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] instr_class,
  output logic       is_store,
  output logic [2:0] exec_alu_op,
  output logic       imm_zext
);

  instr_class_t cls;
  alu_op_t      op_sel;

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OP_LW, OP_SW:    cls = CLS_MEM;
      OP_ADDI, OP_XORI: cls = CLS_I;
      OP_BNE:          cls = CLS_BRANCH;
      OP_J:            cls = CLS_JUMP;
      OP_JAL:          cls = CLS_JAL;
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_SLT: cls = CLS_R;
          FN_JR:                  cls = CLS_JR;
          default:                cls = CLS_ILLEGAL;
        endcase
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

  // R-type picks the op from funct; I-type from the opcode. Anything else
  // defaults to ADD, which is harmless because only execute states use it.
  always_comb begin
    op_sel = ALU_ADD;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_SUB:  op_sel = ALU_SUB;
        FN_SLT:  op_sel = ALU_SLT;
        default: op_sel = ALU_ADD;
      endcase
    end else if (opcode == OP_XORI) begin
      op_sel = ALU_XOR;
    end
  end

  assign instr_class = cls;
  assign exec_alu_op = op_sel;
  assign is_store    = is_store_op(opcode);
  assign imm_zext    = (opcode == OP_XORI);

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Multicycle sequencer for the Lab3 MIPS datapath. Steps the shared datapath
// through fetch/decode/execute/memory/writeback one instruction at a time.
// Memory accesses use a mem_req/mem_ready handshake.
// Parameters:
//   HALT_ON_ILLEGAL  1 = park in ILLEGAL until reset, 0 = NOP and refetch
//   RA_REG           register written by JAL (driven on ra_index)
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   opcode, funct                IR fields
//   zero                         ALU zero flag (same cycle)
//   mem_ready                    memory access completes this cycle
//   mem_req, mem_we, iord        memory request / write / address select
//   ir_we, pc_we, pc_src         IR and PC load controls
//   alu_src_a, alu_src_b, alu_op, imm_zext   ALU controls
//   reg_we, reg_dst, mem_to_reg, ra_index    register file write controls
//   instr_done                   pulse on last cycle of each instruction
//   illegal                      sticky illegal-instruction flag
// ---------------------------------------------------------------------------
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit          HALT_ON_ILLEGAL = 1'b1,
  parameter int unsigned RA_REG          = 31
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       imm_zext,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [4:0] ra_index,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state, next_state;
  logic [2:0] instr_class;
  logic       is_store;
  logic [2:0] exec_alu_op;
  logic       dec_imm_zext;
  logic       illegal_q;

  mips_ctrl_decode u_decode (
    .opcode      (opcode),
    .funct       (funct),
    .instr_class (instr_class),
    .is_store    (is_store),
    .exec_alu_op (exec_alu_op),
    .imm_zext    (dec_imm_zext)
  );

  assign ra_index = 5'(RA_REG);
  assign illegal  = illegal_q;

  // State register and sticky illegal flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_ILLEGAL) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (instr_class)
          CLS_MEM:    next_state = S_MEM_ADDR;
          CLS_R:      next_state = S_EXEC_R;
          CLS_JR:     next_state = S_JR;
          CLS_I:      next_state = S_EXEC_I;
          CLS_BRANCH: next_state = S_BRANCH;
          CLS_JUMP:   next_state = S_JUMP;
          CLS_JAL:    next_state = S_JAL;
          default:    next_state = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  next_state = is_store ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) next_state = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) next_state = S_FETCH;
      S_EXEC_R:    next_state = S_R_WB;
      S_EXEC_I:    next_state = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR:
                   next_state = S_FETCH;
      S_ILLEGAL:   next_state = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
      default:     next_state = S_FETCH;
    endcase
  end

  // Output decode. Moore per state, with the mem_ready / zero qualifiers
  // applied where the handshake or branch outcome is needed. Everything is
  // forced to zero while reset_n is low so a reset abandons any access.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_SRC_ALU;
    alu_src_a  = ALU_A_PC;
    alu_src_b  = ALU_B_RT;
    alu_op     = ALU_ADD;
    imm_zext   = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = REG_DST_RT;
    mem_to_reg = WB_ALUOUT;
    instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = ALU_B_FOUR;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = ALU_B_IMM_SH2;
      end
      S_MEM_ADDR: begin
        alu_src_a = ALU_A_RS;
        alu_src_b = ALU_B_IMM;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_WB: begin
        reg_we     = 1'b1;
        reg_dst    = REG_DST_RT;
        mem_to_reg = WB_MDR;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = ALU_A_RS;
        alu_src_b = ALU_B_RT;
        alu_op    = exec_alu_op;
      end
      S_R_WB: begin
        reg_we     = 1'b1;
        reg_dst    = REG_DST_RD;
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = ALU_A_RS;
        alu_src_b = ALU_B_IMM;
        alu_op    = exec_alu_op;
        imm_zext  = dec_imm_zext;
      end
      S_I_WB: begin
        reg_we     = 1'b1;
        reg_dst    = REG_DST_RT;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        // BNE: the ALU compares rs and rt; branch only when they differ
        alu_src_a  = ALU_A_RS;
        alu_src_b  = ALU_B_RT;
        alu_op     = ALU_SUB;
        pc_src     = PC_SRC_ALUOUT;
        pc_we      = ~zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = PC_SRC_JUMP;
        pc_we      = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4 from fetch, so it is the link value
        pc_src     = PC_SRC_JUMP;
        pc_we      = 1'b1;
        reg_we     = 1'b1;
        reg_dst    = REG_DST_RA;
        mem_to_reg = WB_PC;
        instr_done = 1'b1;
      end
      S_JR: begin
        pc_src     = PC_SRC_RS;
        pc_we      = 1'b1;
        instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        instr_done = !HALT_ON_ILLEGAL;
      end
      default: begin
      end
    endcase
    if (!reset_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = PC_SRC_ALU;
      alu_src_a  = ALU_A_PC;
      alu_src_b  = ALU_B_RT;
      alu_op     = ALU_ADD;
      imm_zext   = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = REG_DST_RT;
      mem_to_reg = WB_ALUOUT;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Self-checking bench for multicycle_control (HALT_ON_ILLEGAL=1, RA_REG=31).
// A per-cycle vector table drives reset_n/opcode/funct/zero/mem_ready and
// names the expected output phase; hand-written sequences then measure
// instruction latency and the constant ra_index.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  localparam logic [5:0] T_RTYPE = 6'h00;
  localparam logic [5:0] T_J     = 6'h02;
  localparam logic [5:0] T_JAL   = 6'h03;
  localparam logic [5:0] T_BNE   = 6'h05;
  localparam logic [5:0] T_ADDI  = 6'h08;
  localparam logic [5:0] T_XORI  = 6'h0E;
  localparam logic [5:0] T_LW    = 6'h23;
  localparam logic [5:0] T_SW    = 6'h2B;
  localparam logic [5:0] T_BAD   = 6'h3F;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_OR    = 6'h25;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       imm_zext;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       instr_done;
  } outs_t;

  typedef enum int {
    P_ZERO, P_FETCH_RDY, P_FETCH_WAIT, P_DECODE, P_MEM_ADDR, P_MEM_READ,
    P_MEM_WB, P_MEM_WRITE_WAIT, P_MEM_WRITE_DONE, P_EXEC_ADD, P_EXEC_SUB,
    P_EXEC_SLT, P_R_WB, P_EXEC_ADDI, P_EXEC_XORI, P_I_WB, P_BR_NOT,
    P_BR_TAKEN, P_JUMP, P_JAL, P_JR
  } phase_t;

  typedef struct {
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       mr;
    phase_t     phase;
    logic       exp_illegal;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_we, pc_we;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       imm_zext, reg_we;
  logic [1:0] reg_dst, mem_to_reg;
  logic [4:0] ra_index;
  logic       instr_done, illegal;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  multicycle_control #(.HALT_ON_ILLEGAL(1'b1), .RA_REG(31)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .imm_zext   (imm_zext),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .ra_index   (ra_index),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Hand-written expected outputs for each phase of an instruction
  function automatic outs_t phase_out(input phase_t p);
    outs_t o;
    o = '0;
    case (p)
      P_FETCH_RDY:      begin o.mem_req = 1; o.alu_src_b = 2'd1; o.ir_we = 1; o.pc_we = 1; end
      P_FETCH_WAIT:     begin o.mem_req = 1; o.alu_src_b = 2'd1; end
      P_DECODE:         begin o.alu_src_b = 2'd3; end
      P_MEM_ADDR:       begin o.alu_src_a = 1; o.alu_src_b = 2'd2; end
      P_MEM_READ:       begin o.mem_req = 1; o.iord = 1; end
      P_MEM_WB:         begin o.reg_we = 1; o.mem_to_reg = 2'd1; o.instr_done = 1; end
      P_MEM_WRITE_WAIT: begin o.mem_req = 1; o.mem_we = 1; o.iord = 1; end
      P_MEM_WRITE_DONE: begin o.mem_req = 1; o.mem_we = 1; o.iord = 1; o.instr_done = 1; end
      P_EXEC_ADD:       begin o.alu_src_a = 1; o.alu_op = 3'd0; end
      P_EXEC_SUB:       begin o.alu_src_a = 1; o.alu_op = 3'd1; end
      P_EXEC_SLT:       begin o.alu_src_a = 1; o.alu_op = 3'd3; end
      P_R_WB:           begin o.reg_we = 1; o.reg_dst = 2'd1; o.instr_done = 1; end
      P_EXEC_ADDI:      begin o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_op = 3'd0; end
      P_EXEC_XORI:      begin o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_op = 3'd2; o.imm_zext = 1; end
      P_I_WB:           begin o.reg_we = 1; o.instr_done = 1; end
      P_BR_NOT:         begin o.alu_src_a = 1; o.alu_op = 3'd1; o.pc_src = 2'd1; o.instr_done = 1; end
      P_BR_TAKEN:       begin o.alu_src_a = 1; o.alu_op = 3'd1; o.pc_src = 2'd1; o.pc_we = 1; o.instr_done = 1; end
      P_JUMP:           begin o.pc_src = 2'd2; o.pc_we = 1; o.instr_done = 1; end
      P_JAL:            begin o.pc_src = 2'd2; o.pc_we = 1; o.reg_we = 1; o.reg_dst = 2'd2; o.mem_to_reg = 2'd2; o.instr_done = 1; end
      P_JR:             begin o.pc_src = 2'd3; o.pc_we = 1; o.instr_done = 1; end
      default:          o = '0;
    endcase
    return o;
  endfunction

  function automatic outs_t actual_out();
    outs_t o;
    o.mem_req    = mem_req;
    o.mem_we     = mem_we;
    o.iord       = iord;
    o.ir_we      = ir_we;
    o.pc_we      = pc_we;
    o.pc_src     = pc_src;
    o.alu_src_a  = alu_src_a;
    o.alu_src_b  = alu_src_b;
    o.alu_op     = alu_op;
    o.imm_zext   = imm_zext;
    o.reg_we     = reg_we;
    o.reg_dst    = reg_dst;
    o.mem_to_reg = mem_to_reg;
    o.instr_done = instr_done;
    return o;
  endfunction

  task automatic add_vec(input logic r, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic mr, input phase_t p, input logic ill);
    vec_t v;
    v.rst_n = r; v.op = op; v.fn = fn; v.z = z; v.mr = mr;
    v.phase = p; v.exp_illegal = ill;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs at the falling edge and let the outputs settle
  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    reset_n   = v.rst_n;
    opcode    = v.op;
    funct     = v.fn;
    zero      = v.z;
    mem_ready = v.mr;
    #1;
  endtask

  task automatic check_output(input int idx, input vec_t v);
    outs_t exp_o, act_o;
    exp_o = phase_out(v.phase);
    act_o = actual_out();
    checks++;
    if (act_o !== exp_o) begin
      failures++;
      $display("[TB] FAIL row%0d_%s outputs got=%h want=%h", idx, v.phase.name(), act_o, exp_o);
    end
    checks++;
    if (illegal !== v.exp_illegal) begin
      failures++;
      $display("[TB] FAIL row%0d_illegal got=%b want=%b", idx, illegal, v.exp_illegal);
    end
  endtask

  // Runs one instruction from FETCH with mem_ready=1 and counts cycles up to
  // and including the instr_done cycle. Called and returns on a falling edge.
  task automatic run_latency(input string name, input logic [5:0] op,
                             input logic [5:0] fn, input int exp_cycles);
    int cycles;
    bit seen;
    cycles = 0;
    seen   = 0;
    opcode = op; funct = fn; zero = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      cycles++;
      if (instr_done === 1'b1) seen = 1;
      @(negedge clk);
    end
    checks++;
    if (!seen || cycles != exp_cycles) begin
      failures++;
      $display("[TB] FAIL latency_%s cycles=%0d seen=%0d want=%0d", name, cycles, seen, exp_cycles);
    end
  endtask

  initial begin
    reset_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // reset state
    add_vec(0, T_RTYPE, F_ADD, 0, 1, P_ZERO, 0);
    // ADD
    add_vec(1, T_RTYPE, F_ADD, 0, 1, P_FETCH_RDY, 0);
    add_vec(1, T_RTYPE, F_ADD, 0, 1, P_DECODE, 0);
    add_vec(1, T_RTYPE, F_ADD, 0, 1, P_EXEC_ADD, 0);
    add_vec(1, T_RTYPE, F_ADD, 0, 1, P_R_WB, 0);
    // SUB
    add_vec(1, T_RTYPE, F_SUB, 0, 1, P_FETCH_RDY, 0);
    add_vec(1, T_RTYPE, F_SUB, 0, 1, P_DECODE, 0);
    add_vec(1, T_RTYPE, F_SUB, 0, 1, P_EXEC_SUB, 0);
    add_vec(1, T_RTYPE, F_SUB, 0, 1, P_R_WB, 0);
    // SLT
    add_vec(1, T_RTYPE, F_SLT, 0, 1, P_FETCH_RDY, 0);
    add_vec(1, T_RTYPE, F_SLT, 0, 1, P_DECODE, 0);
    add_vec(1, T_RTYPE, F_SLT, 0, 1, P_EXEC_SLT, 0);
    add_vec(1, T_RTYPE, F_SLT, 0, 1, P_R_WB, 0);
    // ADDI
    add_vec(1, T_ADDI, 6'h00, 0, 1, P_FETCH_RDY, 0);
    add_vec(1, T_ADDI, 6'h00, 0, 1, P_DECODE, 0);
    add_vec(1, T_ADDI, 6'h00, 0, 1, P_EXEC_ADDI, 0);
    add_vec(1, T_ADDI, 6'h00, 0, 1, P_I_WB, 0);
    // XORI
    add_vec(1, T_XORI, 6'h00, 0, 1, P_FETCH_RDY, 0);
    add_vec(1, T_XORI, 6'h00, 0, 1, P_DECODE, 0);
    add_vec(1, T_XORI, 6'h00, 0, 1, P_EXEC_XORI, 0);
    add_vec(1, T_XORI, 6'h00, 0, 1, P_I_WB, 0);
    // LW, memory stalls 3 cycles in MEM_READ: 8 cycles total
    add_vec(1, T_LW, 6'h00, 0, 1, P_FETCH_RDY, 0);
    add_vec(1, T_LW, 6'h00, 0, 1, P_DECODE, 0);
    add_vec(1, T_LW, 6'h00, 0, 1, P_MEM_ADDR, 0);
    add_vec(1, T_LW, 6'h00, 0, 0, P_MEM_READ, 0);
    add_vec(1, T_LW, 6'h00, 0, 0, P_MEM_READ, 0);
    add_vec(1, T_LW, 6'h00, 0, 0, P_MEM_READ, 0);
    add_vec(1, T_LW, 6'h00, 0, 1, P_MEM_READ, 0);
    add_vec(1, T_LW, 6'h00, 0, 1, P_MEM_WB, 0);
    // SW with one fetch stall and one write stall
    add_vec(1, T_SW, 6'h00, 0, 0, P_FETCH_WAIT, 0);
    add_vec(1, T_SW, 6'h00, 0, 1, P_FETCH_RDY, 0);
    add_vec(1, T_SW, 6'h00, 0, 1, P_DECODE, 0);
    add_vec(1, T_SW, 6'h00, 0, 1, P_MEM_ADDR, 0);
    add_vec(1, T_SW, 6'h00, 0, 0, P_MEM_WRITE_WAIT, 0);
    add_vec(1, T_SW, 6'h00, 0, 1, P_MEM_WRITE_DONE, 0);
    // BNE not taken (zero=1), then taken (zero=0)
    add_vec(1, T_BNE, 6'h00, 1, 1, P_FETCH_RDY, 0);
    add_vec(1, T_BNE, 6'h00, 1, 1, P_DECODE, 0);
    add_vec(1, T_BNE, 6'h00, 1, 1, P_BR_NOT, 0);
    add_vec(1, T_BNE, 6'h00, 0, 1, P_FETCH_RDY, 0);
    add_vec(1, T_BNE, 6'h00, 0, 1, P_DECODE, 0);
    add_vec(1, T_BNE, 6'h00, 0, 1, P_BR_TAKEN, 0);
    // J, JAL, JR
    add_vec(1, T_J,     6'h00, 0, 1, P_FETCH_RDY, 0);
    add_vec(1, T_J,     6'h00, 0, 1, P_DECODE, 0);
    add_vec(1, T_J,     6'h00, 0, 1, P_JUMP, 0);
    add_vec(1, T_JAL,   6'h00, 0, 1, P_FETCH_RDY, 0);
    add_vec(1, T_JAL,   6'h00, 0, 1, P_DECODE, 0);
    add_vec(1, T_JAL,   6'h00, 0, 1, P_JAL, 0);
    add_vec(1, T_RTYPE, F_JR,  0, 1, P_FETCH_RDY, 0);
    add_vec(1, T_RTYPE, F_JR,  0, 1, P_DECODE, 0);
    add_vec(1, T_RTYPE, F_JR,  0, 1, P_JR, 0);
    // reset during a stalled SW abandons the write; then FETCH resumes
    add_vec(1, T_SW,    6'h00, 0, 1, P_FETCH_RDY, 0);
    add_vec(1, T_SW,    6'h00, 0, 1, P_DECODE, 0);
    add_vec(1, T_SW,    6'h00, 0, 1, P_MEM_ADDR, 0);
    add_vec(1, T_SW,    6'h00, 0, 0, P_MEM_WRITE_WAIT, 0);
    add_vec(0, T_SW,    6'h00, 0, 1, P_ZERO, 0);
    add_vec(1, T_RTYPE, F_ADD, 0, 1, P_FETCH_RDY, 0);
    add_vec(1, T_RTYPE, F_ADD, 0, 1, P_DECODE, 0);
    add_vec(1, T_RTYPE, F_ADD, 0, 1, P_EXEC_ADD, 0);
    add_vec(1, T_RTYPE, F_ADD, 0, 1, P_R_WB, 0);
    // illegal opcode halts with sticky flag; only reset clears it
    add_vec(1, T_BAD, 6'h00, 0, 1, P_FETCH_RDY, 0);
    add_vec(1, T_BAD, 6'h00, 0, 1, P_DECODE, 0);
    add_vec(1, T_BAD, 6'h00, 0, 1, P_ZERO, 0);
    add_vec(1, T_BAD, 6'h00, 0, 1, P_ZERO, 1);
    add_vec(1, T_RTYPE, F_ADD, 1, 1, P_ZERO, 1);
    add_vec(1, T_RTYPE, F_ADD, 0, 0, P_ZERO, 1);
    add_vec(0, T_RTYPE, F_ADD, 0, 1, P_ZERO, 1);
    add_vec(1, T_RTYPE, F_ADD, 0, 1, P_FETCH_RDY, 0);
    // unsupported R-type funct also traps
    add_vec(1, T_RTYPE, F_OR, 0, 1, P_DECODE, 0);
    add_vec(1, T_RTYPE, F_OR, 0, 1, P_ZERO, 0);
    add_vec(1, T_RTYPE, F_OR, 0, 1, P_ZERO, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output(i, vecs[i]);
    end

    // Latency sequences from a fresh reset, mem_ready tied high
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run_latency("ADD",  T_RTYPE, F_ADD, 4);
    run_latency("ADDI", T_ADDI,  6'h00, 4);
    run_latency("LW",   T_LW,    6'h00, 5);
    run_latency("SW",   T_SW,    6'h00, 4);
    run_latency("BNE",  T_BNE,   6'h00, 3);
    run_latency("J",    T_J,     6'h00, 3);
    run_latency("JAL",  T_JAL,   6'h00, 3);
    run_latency("JR",   T_RTYPE, F_JR,  3);
    run_latency("SLT",  T_RTYPE, F_SLT, 4);

    checks++;
    if (ra_index !== 5'd31) begin
      failures++;
      $display("[TB] FAIL ra_index got=%0d want=31", ra_index);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
